// File: rtl/jedro_1_csr_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module   : jedro_1_csr_pkg
// Purpose  : Shared types and constants for the jedro_1 CSR arbiter:
//            CSR op encoding, arbiter FSM state encoding, a few machine-mode
//            CSR addresses and the "does this op write" helper.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package jedro_1_csr_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 12;
  localparam int NREQ       = 2;

  // Requester op encoding, matching the funct3[1:0] of the csrr* instructions
  // with RO standing in for the "no write" case.
  typedef enum logic [1:0] {
    CSR_RO = 2'b00,
    CSR_RW = 2'b01,
    CSR_RS = 2'b10,
    CSR_RC = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } csr_arb_state_e;

  localparam logic [ADDR_WIDTH-1:0] CSR_MSCRATCH = 12'h340;
  localparam logic [ADDR_WIDTH-1:0] CSR_MEPC     = 12'h341;
  localparam logic [ADDR_WIDTH-1:0] CSR_MCAUSE   = 12'h342;

  // Set/clear with an all-zero mask must not write (avoids side effects on
  // CSRs with write triggers); RO never writes; RW always writes.
  function automatic logic csr_op_writes(csr_op_e op, logic mask_nz);
    case (op)
      CSR_RW:         return 1'b1;
      CSR_RS, CSR_RC: return mask_nz;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/jedro_1_csr_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : jedro_1_csr_arbiter_if
// Purpose  : Requester-side bus of the CSR arbiter (request handshake plus
//            shared response bus), one lane per requester.
// Ports    : req_valid_i/req_ready_o  request handshake, per requester
//            req_op_i/addr/wdata       request payload, per requester
//            rsp_valid_o               one-cycle response pulse, per requester
//            rsp_rdata_o/rsp_err_o     shared response data / illegal flag
//            modport master = requester side, slave = arbiter side
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface jedro_1_csr_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int NREQ       = 2
);

  logic [NREQ-1:0]                 req_valid_i;
  logic [NREQ-1:0]                 req_ready_o;
  logic [NREQ-1:0][1:0]            req_op_i;
  logic [NREQ-1:0][ADDR_WIDTH-1:0] req_addr_i;
  logic [NREQ-1:0][DATA_WIDTH-1:0] req_wdata_i;
  logic [NREQ-1:0]                 rsp_valid_o;
  logic [DATA_WIDTH-1:0]           rsp_rdata_o;
  logic                            rsp_err_o;

  modport master (
    output req_valid_i, req_op_i, req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

endinterface

`default_nettype wire

// File: rtl/jedro_1_csr_arbiter_rr_arb2.sv
//------------------------------------------------------------------------------
// Module   : jedro_1_rr_arb2
// Purpose  : Two-input round-robin arbiter. Grant is combinational; the
//            last-grant pointer is registered and only moves on an accepted
//            grant, so it also serves as the owner index of the access.
// Ports    : clk_i, rstn_i  clock, async active-low reset
//            i_valid        request valid per input
//            i_advance      grant is being taken this cycle
//            o_grant        one-hot grant (zero when nothing valid)
//            o_last         index of the most recent grant
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module jedro_1_rr_arb2 (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [1:0] i_valid,
  input  logic       i_advance,
  output logic [1:0] o_grant,
  output logic       o_last
);

  logic r_last;

  always_comb begin
    o_grant = i_valid;
    // On contention, favour the port that was not served last.
    if (i_valid[0] && i_valid[1]) begin
      o_grant = r_last ? 2'b01 : 2'b10;
    end
  end

  // Reset value 1 makes port 0 the favoured port after reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_last <= 1'b1;
    end else if (i_advance && (|i_valid)) begin
      r_last <= o_grant[1];
    end
  end

  assign o_last = r_last;

endmodule

`default_nettype wire

// File: rtl/jedro_1_csr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : jedro_1_csr_arbiter
// Purpose  : Shares the CSR file read-modify-write port between the execute
//            stage (port 0) and the debug/host path (port 1). Each access is
//            an atomic IDLE->READ->WRITE->RESP sequence, one per 4 cycles.
// Ports    : clk_i, rstn_i   clock, async active-low reset
//            req_bus         requester handshake/response bus (slave side)
//            csr_re_o        CSR read enable (data returns next cycle)
//            csr_addr_o      CSR address, held through READ and WRITE
//            csr_rdata_i     CSR read data
//            csr_illegal_i   CSR address unimplemented (timed with rdata)
//            csr_we_o        CSR write enable
//            csr_wdata_o     CSR new value
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module jedro_1_csr_arbiter
  import jedro_1_csr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int NREQ       = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  jedro_1_csr_arbiter_if.slave  req_bus,
  output logic                  csr_re_o,
  output logic [ADDR_WIDTH-1:0] csr_addr_o,
  input  logic [DATA_WIDTH-1:0] csr_rdata_i,
  input  logic                  csr_illegal_i,
  output logic                  csr_we_o,
  output logic [DATA_WIDTH-1:0] csr_wdata_o
);

  csr_arb_state_e        r_state;
  csr_arb_state_e        w_state_nxt;
  csr_op_e               r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic                  w_idle;
  logic [NREQ-1:0]       w_grant;
  logic                  w_gnt_sel;
  logic                  w_owner;
  logic [DATA_WIDTH-1:0] w_new_val;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_gnt_sel = w_grant[1];

  // The arbiter's last-grant pointer doubles as the latched owner index:
  // it is loaded on the grant and holds until the next one.
  jedro_1_rr_arb2 u_arb (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .i_valid   (req_bus.req_valid_i),
    .i_advance (w_idle),
    .o_grant   (w_grant),
    .o_last    (w_owner)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
      r_op    <= CSR_RO;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_idle && (|req_bus.req_valid_i)) begin
        r_op    <= csr_op_e'(req_bus.req_op_i[w_gnt_sel]);
        r_addr  <= req_bus.req_addr_i[w_gnt_sel];
        r_wdata <= req_bus.req_wdata_i[w_gnt_sel];
      end
      if (r_state == ST_WRITE) begin
        r_rdata <= csr_rdata_i;
        r_err   <= csr_illegal_i;
      end
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    req_bus.req_ready_o = '0;
    req_bus.rsp_valid_o = '0;
    req_bus.rsp_rdata_o = '0;
    req_bus.rsp_err_o   = 1'b0;
    csr_re_o            = 1'b0;
    csr_addr_o          = '0;
    csr_we_o            = 1'b0;
    csr_wdata_o         = '0;
    w_new_val           = '0;

    case (r_state)
      ST_IDLE: begin
        if (|req_bus.req_valid_i) begin
          req_bus.req_ready_o = w_grant;
          w_state_nxt         = ST_READ;
        end
      end
      ST_READ: begin
        csr_re_o    = 1'b1;
        csr_addr_o  = r_addr;
        w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        csr_addr_o = r_addr;
        case (r_op)
          CSR_RW:  w_new_val = r_wdata;
          CSR_RS:  w_new_val = csr_rdata_i | r_wdata;
          CSR_RC:  w_new_val = csr_rdata_i & ~r_wdata;
          default: w_new_val = csr_rdata_i;
        endcase
        csr_we_o    = !csr_illegal_i && csr_op_writes(r_op, |r_wdata);
        csr_wdata_o = csr_we_o ? w_new_val : '0;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        req_bus.rsp_valid_o[w_owner] = 1'b1;
        // An illegal access must not leak whatever the CSR file drove.
        req_bus.rsp_rdata_o = r_err ? '0 : r_rdata;
        req_bus.rsp_err_o   = r_err;
        w_state_nxt         = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_jedro_1_csr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_jedro_1_csr_arbiter
// Purpose  : Self-checking bench for jedro_1_csr_arbiter. Directed requests
//            push hand-computed responses/writes into queues; a monitor pops
//            and compares whenever the DUT writes the CSR file or responds.
//            A small CSR file model (mscratch, mepc, mcause) sits on the
//            CSR port; other addresses report illegal.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_jedro_1_csr_arbiter;
  import jedro_1_csr_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        csr_re;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata = '0;
  logic        csr_illegal = 1'b0;
  logic        csr_we;
  logic [31:0] csr_wdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int g_cycle = -100;
  int g_port = 0;
  logic [11:0] g_addr = '0;

  typedef struct {int port; logic [31:0] rdata; logic err;} rsp_t;
  typedef struct {logic [11:0] addr; logic [31:0] data;} wr_t;
  rsp_t exp_q[$];
  wr_t  wr_q[$];

  logic [31:0] m_mscratch = 32'h0000_055C;
  logic [31:0] m_mepc     = 32'h0000_1000;
  logic [31:0] m_mcause   = 32'h0000_055C;

  jedro_1_csr_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .NREQ(2)) bus ();

  jedro_1_csr_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .NREQ(2)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .req_bus       (bus),
    .csr_re_o      (csr_re),
    .csr_addr_o    (csr_addr),
    .csr_rdata_i   (csr_rdata),
    .csr_illegal_i (csr_illegal),
    .csr_we_o      (csr_we),
    .csr_wdata_o   (csr_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // CSR file model: registered read data, write on csr_we.
  always @(posedge clk) begin
    if (csr_re) begin
      case (csr_addr)
        CSR_MSCRATCH: begin csr_rdata <= m_mscratch; csr_illegal <= 1'b0; end
        CSR_MEPC:     begin csr_rdata <= m_mepc;     csr_illegal <= 1'b0; end
        CSR_MCAUSE:   begin csr_rdata <= m_mcause;   csr_illegal <= 1'b0; end
        default:      begin csr_rdata <= 32'hBAD0_BAD0; csr_illegal <= 1'b1; end
      endcase
    end
    if (csr_we) begin
      case (csr_addr)
        CSR_MSCRATCH: m_mscratch <= csr_wdata;
        CSR_MEPC:     m_mepc     <= csr_wdata;
        CSR_MCAUSE:   m_mcause   <= csr_wdata;
        default: ;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic exp_rsp(input int p, input logic [31:0] d, input logic e);
    rsp_t r;
    r.port = p; r.rdata = d; r.err = e;
    exp_q.push_back(r);
  endtask

  task automatic exp_wr(input logic [11:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wr_q.push_back(w);
  endtask

  // Present a request on port p and hold it until accepted.
  task automatic issue(input int p, input logic [1:0] op, input logic [11:0] a,
                       input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    bus.req_op_i[p]    = op;
    bus.req_addr_i[p]  = a;
    bus.req_wdata_i[p] = d;
    bus.req_valid_i[p] = 1'b1;
    #1;
    while (!bus.req_ready_o[p] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.req_ready_o[p]) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout port %0d: ready 0 required 1", p);
      bus.req_valid_i[p] = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.req_valid_i[p] = 1'b0;
    end
  endtask

  // Monitor: samples 1 ns before each rising edge.
  always @(negedge clk) begin
    rsp_t e;
    wr_t  w;
    logic [1:0] expv;
    #4;
    if (rstn) begin
      if (|bus.req_ready_o) begin
        chk("ready_onehot", 64'($onehot(bus.req_ready_o)), 64'd1);
        chk("ready_without_valid", 64'(bus.req_ready_o & ~bus.req_valid_i), 64'd0);
        g_cycle = cyc;
        g_port  = bus.req_ready_o[1] ? 1 : 0;
        g_addr  = bus.req_addr_i[g_port];
      end
      if (cyc == g_cycle + 1) begin
        chk("csr_re_in_read", 64'(csr_re), 64'd1);
        chk("csr_addr_in_read", 64'(csr_addr), 64'(g_addr));
      end
      if (csr_we) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0h data %0h, no write expected", csr_addr, csr_wdata);
        end else begin
          w = wr_q.pop_front();
          chk("write_addr", 64'(csr_addr), 64'(w.addr));
          chk("write_data", 64'(csr_wdata), 64'(w.data));
          chk("write_cycle", 64'(cyc), 64'(g_cycle + 2));
        end
      end
      if (|bus.rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: valid %0b data %0h, no response expected",
                   bus.rsp_valid_o, bus.rsp_rdata_o);
        end else begin
          e = exp_q.pop_front();
          expv = (e.port == 1) ? 2'b10 : 2'b01;
          chk("rsp_port", 64'(bus.rsp_valid_o), 64'(expv));
          chk("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(e.rdata));
          chk("rsp_err", 64'(bus.rsp_err_o), 64'(e.err));
          chk("rsp_cycle", 64'(cyc), 64'(g_cycle + 3));
        end
      end
    end
  end

  task automatic chk_quiet(input string tag);
    chk({tag, "_re"},    64'(csr_re), 64'd0);
    chk({tag, "_we"},    64'(csr_we), 64'd0);
    chk({tag, "_addr"},  64'(csr_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(csr_wdata), 64'd0);
    chk({tag, "_rsp"},   64'(bus.rsp_valid_o), 64'd0);
    chk({tag, "_ready"}, 64'(bus.req_ready_o), 64'd0);
  endtask

  initial begin
    bus.req_valid_i = '0;
    bus.req_op_i    = '0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;

    repeat (3) @(posedge clk);
    #1 chk_quiet("reset");
    @(negedge clk);
    rstn = 1'b1;
    #1 chk_quiet("post_reset");

    // RS mscratch 0x55C | 0x3 -> 0x55F
    exp_wr(CSR_MSCRATCH, 32'h55F);
    exp_rsp(0, 32'h55C, 1'b0);
    issue(0, CSR_RS, CSR_MSCRATCH, 32'h3);
    // RO mscratch confirms the write
    exp_rsp(0, 32'h55F, 1'b0);
    issue(0, CSR_RO, CSR_MSCRATCH, 32'h0);
    // RC mcause 0x55C & ~0x4 -> 0x558
    exp_wr(CSR_MCAUSE, 32'h558);
    exp_rsp(0, 32'h55C, 1'b0);
    issue(0, CSR_RC, CSR_MCAUSE, 32'h4);
    // zero-mask set/clear and RO: no writes
    exp_rsp(1, 32'h55F, 1'b0);
    issue(1, CSR_RS, CSR_MSCRATCH, 32'h0);
    exp_rsp(1, 32'h558, 1'b0);
    issue(1, CSR_RC, CSR_MCAUSE, 32'h0);
    exp_rsp(0, 32'h1000, 1'b0);
    issue(0, CSR_RO, CSR_MEPC, 32'h0);
    // illegal address RW all-ones: no write, err, data forced to 0
    exp_rsp(1, 32'h0, 1'b1);
    issue(1, CSR_RW, 12'h7C0, 32'hFFFF_FFFF);

    // contention: expected grant order 0,1,0,1
    exp_wr(CSR_MEPC, 32'h2000);
    exp_rsp(0, 32'h1000, 1'b0);
    exp_rsp(1, 32'h558, 1'b0);
    exp_rsp(0, 32'h2000, 1'b0);
    exp_wr(CSR_MCAUSE, 32'h11);
    exp_rsp(1, 32'h558, 1'b0);
    fork
      begin
        issue(0, CSR_RW, CSR_MEPC, 32'h2000);
        issue(0, CSR_RO, CSR_MEPC, 32'h0);
      end
      begin
        issue(1, CSR_RO, CSR_MCAUSE, 32'h0);
        issue(1, CSR_RW, CSR_MCAUSE, 32'h11);
      end
    join
    repeat (5) @(posedge clk);

    // reset during READ aborts the access
    issue(0, CSR_RW, CSR_MSCRATCH, 32'hDEAD);
    #1 rstn = 1'b0;
    g_cycle = -100;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1 chk_quiet("abort");
    // pointer back to port 0; mscratch untouched by the aborted RW
    exp_rsp(0, 32'h55F, 1'b0);
    exp_rsp(1, 32'h2000, 1'b0);
    fork
      issue(0, CSR_RO, CSR_MSCRATCH, 32'h0);
      issue(1, CSR_RO, CSR_MEPC, 32'h0);
    join
    repeat (6) @(posedge clk);

    chk("pending_responses", 64'(exp_q.size()), 64'd0);
    chk("pending_writes", 64'(wr_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
